// File: rtl/pipediv_stream.sv
// pipediv_stream: fully pipelined restoring divider with valid/ready streaming, signed mode, dbz/ovf flags and tag
module pipediv_stream #(
    parameter int DIVIDENDLEN    = 16,
    parameter int DIVISORLEN     = 8,
    parameter int BITS_PER_STAGE = 1,
    parameter int TAGW           = 4
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_in_valid,
    output logic                   o_in_ready,
    input  logic                   i_in_signed,
    input  logic [DIVIDENDLEN-1:0] i_dividend,
    input  logic [DIVISORLEN-1:0]  i_divisor,
    input  logic [TAGW-1:0]        i_in_tag,
    output logic                   o_out_valid,
    input  logic                   i_out_ready,
    output logic [DIVIDENDLEN-1:0] o_quotient,
    output logic [DIVISORLEN-1:0]  o_remainder,
    output logic                   o_dbz,
    output logic                   o_ovf,
    output logic [TAGW-1:0]        o_out_tag
);
    localparam int N = DIVIDENDLEN;
    localparam int M = DIVISORLEN;
    localparam int B = BITS_PER_STAGE;
    localparam int L = N / B;
    localparam int W = N + M - 1;

    logic            r_vld [L];
    logic [W-1:0]    r_pr  [L];
    logic [M-1:0]    r_dv  [L];
    logic [N-1:0]    r_q   [L];
    logic            r_nq  [L];
    logic            r_nr  [L];
    logic            r_dbz [L];
    logic            r_ovf [L];
    logic [TAGW-1:0] r_tag [L];

    logic         w_stall;
    logic         w_sn;
    logic         w_sd;
    logic [N-1:0] w_an;
    logic [M-1:0] w_ad;
    logic         w_unused;

    assign w_stall     = o_out_valid & ~i_out_ready;
    assign o_in_ready  = ~w_stall;
    assign w_sn        = i_in_signed & i_dividend[N-1];
    assign w_sd        = i_in_signed & i_divisor[M-1];
    assign w_an        = w_sn ? -i_dividend : i_dividend;
    assign w_ad        = w_sd ? -i_divisor : i_divisor;
    assign o_out_valid = r_vld[L-1];
    assign o_quotient  = r_q[L-1];
    assign o_remainder = r_pr[L-1][M-1:0];
    assign o_dbz       = r_dbz[L-1];
    assign o_ovf       = r_ovf[L-1];
    assign o_out_tag   = r_tag[L-1];
    // The last stage holds only the formatted result; its raw divisor/sign state is dead
    assign w_unused    = ^{r_pr[L-1][W-1:M], r_dv[L-1], r_nq[L-1], r_nr[L-1]};

    genvar k;
    generate
        for (k = 0; k < L; k++) begin : g_stage
            logic            w_v;
            logic            w_nq;
            logic            w_nr;
            logic            w_z;
            logic            w_o;
            logic [TAGW-1:0] w_t;
            logic [W-1:0]    w_pi;
            logic [W-1:0]    w_po;
            logic [W-1:0]    w_pn;
            logic [W-1:0]    w_sh;
            logic [M-1:0]    w_di;
            logic [N-1:0]    w_qi;
            logic [N-1:0]    w_qo;
            logic [N-1:0]    w_qn;
            if (k == 0) begin : g_first
                // Stage 0 works on magnitudes; signs and special cases are decided here and carried along
                assign w_v  = i_in_valid;
                assign w_pi = W'(w_an);
                assign w_di = w_ad;
                assign w_qi = '0;
                assign w_nq = w_sn ^ w_sd;
                assign w_nr = w_sn;
                assign w_z  = i_divisor == '0;
                assign w_o  = i_in_signed & (i_dividend == {1'b1, {(N-1){1'b0}}}) & (&i_divisor);
                assign w_t  = i_in_tag;
            end else begin : g_next
                assign w_v  = r_vld[k-1];
                assign w_pi = r_pr[k-1];
                assign w_di = r_dv[k-1];
                assign w_qi = r_q[k-1];
                assign w_nq = r_nq[k-1];
                assign w_nr = r_nr[k-1];
                assign w_z  = r_dbz[k-1];
                assign w_o  = r_ovf[k-1];
                assign w_t  = r_tag[k-1];
            end
            // Resolve this stage's quotient bits MSB first by compare-and-subtract against the shifted divisor
            always_comb begin
                w_po = w_pi;
                w_qo = w_qi;
                w_sh = '0;
                for (int j = 0; j < B; j++) begin
                    w_sh = W'(w_di) << (N - 1 - k * B - j);
                    w_qo = w_qo | (N'(w_po >= w_sh) << (N - 1 - k * B - j));
                    w_po = (w_po >= w_sh) ? w_po - w_sh : w_po;
                end
            end
            if (k == L - 1) begin : g_fmt
                logic [M-1:0] w_r;
                logic         w_unused_pr;
                assign w_r         = w_nr ? -w_po[M-1:0] : w_po[M-1:0];
                assign w_qn        = w_z ? '1 : (w_nq ? -w_qo : w_qo);
                assign w_pn        = w_z ? '0 : W'(w_r);
                assign w_unused_pr = ^w_po[W-1:M];
            end else begin : g_raw
                assign w_qn = w_qo;
                assign w_pn = w_po;
            end
            // Stage register: the whole pipe freezes together while the output is back-pressured
            always_ff @(posedge i_clock) begin
                if (i_reset) begin
                    r_vld[k] <= 1'b0;
                    r_pr[k]  <= '0;
                    r_dv[k]  <= '0;
                    r_q[k]   <= '0;
                    r_nq[k]  <= 1'b0;
                    r_nr[k]  <= 1'b0;
                    r_dbz[k] <= 1'b0;
                    r_ovf[k] <= 1'b0;
                    r_tag[k] <= '0;
                end else if (!w_stall) begin
                    r_vld[k] <= w_v;
                    r_pr[k]  <= w_pn;
                    r_dv[k]  <= w_di;
                    r_q[k]   <= w_qn;
                    r_nq[k]  <= w_nq;
                    r_nr[k]  <= w_nr;
                    r_dbz[k] <= w_z;
                    r_ovf[k] <= w_o;
                    r_tag[k] <= w_t;
                end
            end
        end
    endgenerate
endmodule
